// File: rtl/stage_mem.sv
// Memory stage of the 3-stage RISC-V pipeline.
// Issues loads/stores over a req/gnt/rvalid port, aligns and extends load data,
// stalls upstream while an access is outstanding, and registers the W stage.
//
// Handshake: dmem_req is a valid that, once raised, stays high with address,
// we, wdata and wstrb stable until the cycle dmem_gnt is sampled high; that
// cycle is the transfer. For loads, dmem_rvalid qualifies dmem_rdata and comes
// no earlier than the cycle after gnt. There is no back-pressure on rvalid.
module stage_mem #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_M,
  input  logic [XLEN-1:0] alu_out_M,
  input  logic [XLEN-1:0] store_data_M,
  input  logic            mem_read_M,
  input  logic            mem_write_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] jump_result_plus4_M,
  input  logic [1:0]      wb_sel_M,
  input  logic            reg_write_M,
  input  logic [4:0]      rd_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_M,
  output logic            misalign_M,
  output logic [XLEN-1:0] alu_outW,
  output logic [XLEN-1:0] mem_resultW,
  output logic [XLEN-1:0] jump_result_plus4W,
  output logic [1:0]      wb_selW,
  output logic            reg_writeW,
  output logic [4:0]      rdW,
  output logic [1:0]      memStateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memState_t;

  memState_t state;

  logic            memop;
  logic            isLoad;
  logic            isStore;
  logic            misalign;
  logic            alignedMemop;
  logic            issue;
  logic            complete;
  logic [1:0]      addrLo;
  logic [1:0]      addrLoCap;
  logic [2:0]      funct3Cap;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] loadVal;

  // A load wins when both read and write are decoded.
  assign memop   = valid_M & (mem_read_M | mem_write_M);
  assign isLoad  = mem_read_M;
  assign isStore = mem_write_M & ~mem_read_M;
  assign addrLo  = alu_out_M[1:0];

  // Halfwords need addr[0]=0, words need addr[1:0]=0; the sign bit of
  // funct3 does not affect size.
  always_comb begin
    misalign = 1'b0;
    case (funct3_M[1:0])
      2'b01:   misalign = addrLo[0];
      2'b10:   misalign = (addrLo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  assign alignedMemop = memop & ~misalign;

  // Request is live for a fresh aligned access in IDLE and held through REQ.
  assign issue = ((state == IDLE) & alignedMemop) | (state == REQ);

  // Decide whether the instruction in M leaves the stage this cycle.
  always_comb begin
    complete = 1'b0;
    case (state)
      IDLE:    complete = (valid_M & ~memop) | (alignedMemop & isStore & dmem_gnt);
      REQ:     complete = isStore & dmem_gnt;
      RESP:    complete = dmem_rvalid;
      default: complete = 1'b0;
    endcase
  end

  assign dmem_req    = rst_n & issue;
  assign dmem_we     = dmem_req & isStore;
  assign dmem_addr   = {alu_out_M[XLEN-1:2], 2'b00};
  assign stall_M     = rst_n & ~complete & (((state == IDLE) & alignedMemop) | (state != IDLE));
  assign misalign_M  = rst_n & (state == IDLE) & memop & misalign;
  assign memStateDbg = state;

  // Replicate store data across byte lanes and build the byte strobes.
  always_comb begin
    dmem_wdata = store_data_M;
    dmem_wstrb = 4'b0000;
    case (funct3_M[1:0])
      2'b00: begin
        dmem_wdata = {4{store_data_M[7:0]}};
        if (isStore) dmem_wstrb = 4'b0001 << addrLo;
      end
      2'b01: begin
        dmem_wdata = {2{store_data_M[15:0]}};
        if (isStore) dmem_wstrb = 4'b0011 << addrLo;
      end
      default: begin
        dmem_wdata = store_data_M;
        if (isStore) dmem_wstrb = 4'b1111;
      end
    endcase
  end

  // Extract the addressed byte/half using the offset captured at gnt.
  assign shifted = dmem_rdata >> {addrLoCap, 3'b000};

  always_comb begin
    loadVal = dmem_rdata;
    case (funct3Cap)
      3'b000:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadVal = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  loadVal = shifted;
      3'b100:  loadVal = {24'h0, shifted[7:0]};
      3'b101:  loadVal = {16'h0, shifted[15:0]};
      default: loadVal = dmem_rdata;
    endcase
  end

  // Access FSM; addr offset and funct3 are latched when a load is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addrLoCap <= 2'b00;
      funct3Cap <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (alignedMemop) begin
            if (dmem_gnt) begin
              if (isLoad) begin
                state     <= RESP;
                addrLoCap <= addrLo;
                funct3Cap <= funct3_M;
              end
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (isLoad) begin
              state     <= RESP;
              addrLoCap <= addrLo;
              funct3Cap <= funct3_M;
            end else begin
              state <= IDLE;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // W-stage registers: load on completion, otherwise insert a bubble and
  // hold the data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_outW           <= '0;
      mem_resultW        <= '0;
      jump_result_plus4W <= '0;
      wb_selW            <= 2'b00;
      reg_writeW         <= 1'b0;
      rdW                <= 5'd0;
    end else if (complete) begin
      alu_outW           <= alu_out_M;
      mem_resultW        <= (state == RESP) ? loadVal : '0;
      jump_result_plus4W <= jump_result_plus4_M;
      wb_selW            <= wb_sel_M;
      reg_writeW         <= reg_write_M;
      rdW                <= rd_M;
    end else begin
      wb_selW    <= 2'b00;
      reg_writeW <= 1'b0;
      rdW        <= 5'd0;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: single-cycle vectors from a table plus
// hand-written multi-cycle load, delayed-grant store and reset-abort sequences.
module tb_stage_mem;

  logic        clk;
  logic        rst_n;
  logic        valid_M;
  logic [31:0] alu_out_M;
  logic [31:0] store_data_M;
  logic        mem_read_M;
  logic        mem_write_M;
  logic [2:0]  funct3_M;
  logic [31:0] jump_result_plus4_M;
  logic [1:0]  wb_sel_M;
  logic        reg_write_M;
  logic [4:0]  rd_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_M;
  logic        misalign_M;
  logic [31:0] alu_outW;
  logic [31:0] mem_resultW;
  logic [31:0] jump_result_plus4W;
  logic [1:0]  wb_selW;
  logic        reg_writeW;
  logic [4:0]  rdW;
  logic [1:0]  memStateDbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  stage_mem #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .alu_out_M(alu_out_M),
    .store_data_M(store_data_M), .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .funct3_M(funct3_M), .jump_result_plus4_M(jump_result_plus4_M), .wb_sel_M(wb_sel_M),
    .reg_write_M(reg_write_M), .rd_M(rd_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_M(stall_M), .misalign_M(misalign_M), .alu_outW(alu_outW),
    .mem_resultW(mem_resultW), .jump_result_plus4W(jump_result_plus4W),
    .wb_selW(wb_selW), .reg_writeW(reg_writeW), .rdW(rdW), .memStateDbg(memStateDbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic        regw;
    logic [4:0]  rd;
    logic        gnt;
    logic        eReq;
    logic        eWe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [3:0]  eWstrb;
    logic        eMis;
    logic        eDone;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string name, input logic valid, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic ld, input logic st,
                              input logic [2:0] f3, input logic regw, input logic [4:0] rd,
                              input logic gnt, input logic eReq, input logic eWe,
                              input logic [31:0] eAddr, input logic [31:0] eWdata,
                              input logic [3:0] eWstrb, input logic eMis, input logic eDone);
    vec_t v;
    v.name = name; v.valid = valid; v.addr = addr; v.sdata = sdata; v.ld = ld; v.st = st;
    v.f3 = f3; v.regw = regw; v.rd = rd; v.gnt = gnt; v.eReq = eReq; v.eWe = eWe;
    v.eAddr = eAddr; v.eWdata = eWdata; v.eWstrb = eWstrb; v.eMis = eMis; v.eDone = eDone;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver: present one M-stage instruction
  task automatic drive_m(input logic valid, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic regw, input logic [4:0] rd);
    valid_M             = valid;
    alu_out_M           = addr;
    store_data_M        = sdata;
    mem_read_M          = ld;
    mem_write_M         = st;
    funct3_M            = f3;
    reg_write_M         = regw;
    rd_M                = rd;
    wb_sel_M            = 2'b01;
    jump_result_plus4_M = addr + 32'd4;
  endtask

  task automatic idle_m();
    drive_m(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  initial begin
    int stalls;
    bit done;

    vecs[0] = mk("add",      1, 32'h0000_1234, 32'h0,         0, 0, 3'b000, 1, 5'd5,  0,
                 0, 0, 32'h0,         32'h0,         4'b0000, 0, 1);
    vecs[1] = mk("sb_3001",  1, 32'h0000_3001, 32'h0000_00AB, 0, 1, 3'b000, 0, 5'd0,  1,
                 1, 1, 32'h0000_3000, 32'hABAB_ABAB, 4'b0010, 0, 1);
    vecs[2] = mk("sh_3002",  1, 32'h0000_3002, 32'h1234_CDEF, 0, 1, 3'b001, 0, 5'd0,  1,
                 1, 1, 32'h0000_3000, 32'hCDEF_CDEF, 4'b1100, 0, 1);
    vecs[3] = mk("sw_3004",  1, 32'h0000_3004, 32'hDEAD_BEEF, 0, 1, 3'b010, 0, 5'd0,  1,
                 1, 1, 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111, 0, 1);
    vecs[4] = mk("lw_mis",   1, 32'h0000_4002, 32'h0,         1, 0, 3'b010, 1, 5'd3,  1,
                 0, 0, 32'h0,         32'h0,         4'b0000, 1, 0);
    vecs[5] = mk("sh_mis",   1, 32'h0000_3001, 32'h0000_5555, 0, 1, 3'b001, 0, 5'd0,  1,
                 0, 0, 32'h0,         32'h0,         4'b0000, 1, 0);
    vecs[6] = mk("invalid",  0, 32'h0000_0100, 32'h0,         1, 0, 3'b010, 1, 5'd4,  0,
                 0, 0, 32'h0,         32'h0,         4'b0000, 0, 0);
    vecs[7] = mk("add_max",  1, 32'hFFFF_FFFF, 32'h0,         0, 0, 3'b000, 1, 5'd31, 0,
                 0, 0, 32'h0,         32'h0,         4'b0000, 0, 1);
    vecs[8] = mk("lhu_mis",  1, 32'h0000_2003, 32'h0,         1, 0, 3'b101, 1, 5'd6,  1,
                 0, 0, 32'h0,         32'h0,         4'b0000, 1, 0);
    vecs[9] = mk("sb_3003",  1, 32'h0000_3003, 32'h0000_005A, 0, 1, 3'b000, 0, 5'd0,  1,
                 1, 1, 32'h0000_3000, 32'h5A5A_5A5A, 4'b1000, 0, 1);

    // Reset: outputs forced low even with a memop presented
    rst_n = 1'b0;
    idle_m();
    drive_m(1'b1, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd2);
    #12;
    chk("rst_req",      {31'h0, dmem_req},   32'h0);
    chk("rst_stall",    {31'h0, stall_M},    32'h0);
    chk("rst_regw",     {31'h0, reg_writeW}, 32'h0);
    chk("rst_aluW",     alu_outW,            32'h0);
    chk("rst_state",    {30'h0, memStateDbg}, 32'h0);
    @(negedge clk);
    idle_m();
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_m(vecs[i].valid, vecs[i].addr, vecs[i].sdata, vecs[i].ld, vecs[i].st,
              vecs[i].f3, vecs[i].regw, vecs[i].rd);
      dmem_gnt = vecs[i].gnt;
      #1;
      chk({vecs[i].name, "_req"},   {31'h0, dmem_req},   {31'h0, vecs[i].eReq});
      chk({vecs[i].name, "_stall"}, {31'h0, stall_M},    32'h0);
      chk({vecs[i].name, "_mis"},   {31'h0, misalign_M}, {31'h0, vecs[i].eMis});
      if (vecs[i].eReq) begin
        chk({vecs[i].name, "_we"},    {31'h0, dmem_we},    {31'h0, vecs[i].eWe});
        chk({vecs[i].name, "_addr"},  dmem_addr,           vecs[i].eAddr);
        chk({vecs[i].name, "_wdata"}, dmem_wdata,          vecs[i].eWdata);
        chk({vecs[i].name, "_wstrb"}, {28'h0, dmem_wstrb}, {28'h0, vecs[i].eWstrb});
      end
      @(posedge clk);
      #1;
      if (vecs[i].eDone) begin
        chk({vecs[i].name, "_aluW"}, alu_outW,            vecs[i].addr);
        chk({vecs[i].name, "_regW"}, {31'h0, reg_writeW}, {31'h0, vecs[i].regw});
        chk({vecs[i].name, "_rdW"},  {27'h0, rdW},        {27'h0, vecs[i].rd});
        chk({vecs[i].name, "_wbW"},  {30'h0, wb_selW},    32'h1);
        chk({vecs[i].name, "_jW"},   jump_result_plus4W,  vecs[i].addr + 32'd4);
        chk({vecs[i].name, "_memW"}, mem_resultW,         32'h0);
      end else begin
        chk({vecs[i].name, "_regW"}, {31'h0, reg_writeW}, 32'h0);
        chk({vecs[i].name, "_rdW"},  {27'h0, rdW},        32'h0);
        chk({vecs[i].name, "_wbW"},  {30'h0, wb_selW},    32'h0);
      end
      chk({vecs[i].name, "_state"}, {30'h0, memStateDbg}, 32'h0);
    end

    // LB at 0x1003, immediate gnt, rvalid next cycle
    @(negedge clk);
    drive_m(1'b1, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7);
    dmem_gnt = 1'b1;
    exp_q.push_back(32'hFFFF_FF80);
    #1;
    chk("lb_req",   {31'h0, dmem_req},   32'h1);
    chk("lb_we",    {31'h0, dmem_we},    32'h0);
    chk("lb_addr",  dmem_addr,           32'h0000_1000);
    chk("lb_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    chk("lb_stall", {31'h0, stall_M},    32'h1);
    @(posedge clk); #1;
    chk("lb_state_resp", {30'h0, memStateDbg}, 32'h2);
    chk("lb_bubble",     {31'h0, reg_writeW},  32'h0);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_0000;
    #1;
    chk("lb_stall_done", {31'h0, stall_M},  32'h0);
    chk("lb_req_resp",   {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    chk("lb_memW", mem_resultW, exp_q.pop_front());
    chk("lb_regW", {31'h0, reg_writeW}, 32'h1);
    chk("lb_rdW",  {27'h0, rdW},        32'd7);
    @(negedge clk);
    idle_m();

    // LHU at 0x2002: gnt after 3 cycles, rvalid 2 cycles later
    exp_q.push_back(32'h0000_BEEF);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (c == 0) drive_m(1'b1, 32'h0000_2002, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 5'd8);
      dmem_gnt    = (c == 3);
      dmem_rvalid = (c == 5);
      dmem_rdata  = (c == 5) ? 32'hBEEF_1234 : 32'h0;
      #1;
      if (c <= 3) chk("lhu_req_held", {31'h0, dmem_req}, 32'h1);
      if (stall_M) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      if (!done) chk("lhu_bubble", {31'h0, reg_writeW}, 32'h0);
    end
    chk("lhu_completed", {31'h0, done},  32'h1);
    chk("lhu_stalls",    stalls,         32'd5);
    chk("lhu_memW",      mem_resultW,    exp_q.pop_front());
    chk("lhu_regW",      {31'h0, reg_writeW}, 32'h1);
    @(negedge clk);
    idle_m();

    // SW with delayed gnt: one stall cycle in REQ, then completes
    @(negedge clk);
    drive_m(1'b1, 32'h0000_6000, 32'h1122_3344, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0);
    #1;
    chk("sw_wait_stall", {31'h0, stall_M},  32'h1);
    chk("sw_wait_req",   {31'h0, dmem_req}, 32'h1);
    @(posedge clk); #1;
    chk("sw_state_req",  {30'h0, memStateDbg}, 32'h1);
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1;
    chk("sw_gnt_stall",  {31'h0, stall_M}, 32'h0);
    chk("sw_gnt_wstrb",  {28'h0, dmem_wstrb}, 32'hF);
    @(posedge clk); #1;
    chk("sw_state_idle", {30'h0, memStateDbg}, 32'h0);
    chk("sw_aluW",       alu_outW, 32'h0000_6000);
    @(negedge clk);
    idle_m();

    // Reset while in RESP, then a stale rvalid must be ignored
    @(negedge clk);
    drive_m(1'b1, 32'h0000_5000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    chk("rr_state_resp", {30'h0, memStateDbg}, 32'h2);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_state",  {30'h0, memStateDbg}, 32'h0);
    chk("rr_aluW",   alu_outW,             32'h0);
    chk("rr_jW",     jump_result_plus4W,   32'h0);
    chk("rr_memW",   mem_resultW,          32'h0);
    chk("rr_req",    {31'h0, dmem_req},    32'h0);
    chk("rr_stall",  {31'h0, stall_M},     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_M     = 1'b0;
    mem_read_M  = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("rr_stale_regW", {31'h0, reg_writeW},  32'h0);
    chk("rr_stale_memW", mem_resultW,          32'h0);
    chk("rr_stale_rdW",  {27'h0, rdW},         32'h0);
    chk("rr_stale_state", {30'h0, memStateDbg}, 32'h0);
    @(negedge clk);
    idle_m();

    // Final report
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
